// File: rtl/ram4_arbiter.sv
// ram4_arbiter
//   Two-requester round-robin arbiter and access sequencer for the 4-word
//   register-file RAM. A winning request is latched in IDLE, presented to the
//   RAM for exactly one ACCESS cycle, and acknowledged in the RESP cycle with
//   the word the RAM held at that address (read-before-write on writes).
//
// Ports
//   clk, clr                 clock; synchronous active-high reset
//   req_a/we_a/addr_a/wdata_a  requester A (instruction fetch) request
//   ack_a, rdata_a           one-cycle ack to A and its read data
//   req_b/we_b/addr_b/wdata_b  requester B (load/store) request
//   ack_b, rdata_b           one-cycle ack to B and its read data
//   ram_addr/ram_din/ram_we  RAM inputs (this block is their only driver)
//   ram_dout                 RAM combinational read data
//   busy                     high in ACCESS and RESP
module ram4_arbiter #(
    parameter int WORDSIZE  = 8,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 req_a,
    input  logic                 we_a,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [WORDSIZE-1:0]  wdata_a,
    output logic                 ack_a,
    output logic [WORDSIZE-1:0]  rdata_a,
    input  logic                 req_b,
    input  logic                 we_b,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [WORDSIZE-1:0]  wdata_b,
    output logic                 ack_b,
    output logic [WORDSIZE-1:0]  rdata_b,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORDSIZE-1:0]  ram_din,
    output logic                 ram_we,
    input  logic [WORDSIZE-1:0]  ram_dout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state, state_next;
    logic                  last_b;   // 1: B was served last, so A wins a tie
    logic                  owner_b;  // 1: the access in flight belongs to B
    logic [ADDR_SIZE-1:0]  lat_addr;
    logic [WORDSIZE-1:0]   lat_wdata;
    logic                  lat_we;
    logic                  any_req;
    logic                  grant_b;

    assign any_req = req_a | req_b;
    // B wins when it is alone, or when both ask and A was served last.
    assign grant_b = req_b & (~req_a | ~last_b);

    // NOTE: state_next gets its default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all registers use non-blocking assignments so every flop samples
    // the pre-edge values; the RAM read data captured at the end of ACCESS is
    // therefore the word before the write commits.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner_b   <= grant_b;
                last_b    <= grant_b;
                lat_addr  <= grant_b ? addr_b  : addr_a;
                lat_wdata <= grant_b ? wdata_b : wdata_a;
                lat_we    <= grant_b ? we_b    : we_a;
            end
            if (state == ACCESS) begin
                if (owner_b) rdata_b <= ram_dout;
                else         rdata_a <= ram_dout;
            end
        end
    end

    // The latched request drives the RAM continuously; only the write enable
    // is gated, so a write can happen in ACCESS and nowhere else.
    assign ram_addr = lat_addr;
    assign ram_din  = lat_wdata;
    assign ram_we   = (state == ACCESS) & lat_we;
    assign ack_a    = (state == RESP) & ~owner_b;
    assign ack_b    = (state == RESP) &  owner_b;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram4_arbiter.sv
// Testbench for ram4_arbiter: a behavioural 4x8 RAM is attached to the RAM
// port, directed requests push their expected read data into per-requester
// queues, and a monitor pops and compares whenever an ack appears.
module tb_ram4_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_a, we_a, req_b, we_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b, ram_we, busy;
    logic [7:0] rdata_a, rdata_b, ram_din, ram_dout;
    logic [1:0] ram_addr;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         order_log[$];   // 0 = A acked, 1 = B acked

    ram4_arbiter #(.WORDSIZE(8), .ADDR_SIZE(2)) dut (
        .clk(clk), .clr(clr),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    logic [7:0] mem [4];
    initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every ack against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (ack_a && ack_b) check("both acks high", 1, 0);
        if (ack_a) begin
            order_log.push_back(1'b0);
            if (exp_a.size() == 0) check("unexpected ack_a", 1, 0);
            else check("rdata_a", rdata_a, exp_a.pop_front());
        end
        if (ack_b) begin
            order_log.push_back(1'b1);
            if (exp_b.size() == 0) check("unexpected ack_b", 1, 0);
            else check("rdata_b", rdata_b, exp_b.pop_front());
        end
    end

    // Raise a request (caller is already at a negedge).
    task automatic start_req(input bit port, input bit we, input logic [1:0] addr,
                             input logic [7:0] data, input logic [7:0] exp,
                             input bit expect_ack);
        if (port) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data;
            if (expect_ack) exp_b.push_back(exp);
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data;
            if (expect_ack) exp_a.push_back(exp);
        end
    endtask

    // Wait (bounded) for this port's ack, check the RAM drive seen in the
    // ACCESS cycle just before it, then drop req at the following negedge.
    task automatic wait_ack(input bit port, input bit we, input logic [1:0] addr,
                            output int cycles);
        bit         got = 1'b0;
        logic       prev_we = 1'b0;
        logic [1:0] prev_addr = 2'd0;
        cycles = 0;
        while (!got && cycles < 12) begin
            prev_we   = ram_we;
            prev_addr = ram_addr;
            @(posedge clk); #1;
            cycles++;
            got = port ? ack_b : ack_a;
        end
        if (!got) begin
            check(port ? "ack_b timeout" : "ack_a timeout", 0, 1);
        end else begin
            check("ram_we in ACCESS", prev_we, we);
            check("ram_addr in ACCESS", prev_addr, addr);
            check("ram_we in RESP", ram_we, 0);
        end
        @(negedge clk);
        if (port) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        clr = 1'b1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        do_reset();

        // Reset state
        check("reset ack_a", ack_a, 0);
        check("reset ack_b", ack_b, 0);
        check("reset rdata_a", rdata_a, 0);
        check("reset rdata_b", rdata_b, 0);
        check("reset ram_addr", ram_addr, 0);
        check("reset ram_din", ram_din, 0);
        check("reset ram_we", ram_we, 0);
        check("reset busy", busy, 0);

        // Preload word 2 = 0x5A via B (old contents 0x00), then A reads it.
        start_req(1, 1, 2'd2, 8'h5A, 8'h00, 1);
        wait_ack(1, 1, 2'd2, cyc);
        @(negedge clk);
        start_req(0, 0, 2'd2, 8'h00, 8'h5A, 1);
        wait_ack(0, 0, 2'd2, cyc);
        check("read latency A", cyc, 2);
        check("mem[2] after preload", mem[2], 8'h5A);

        // B writes 0xC3 to addr 1 (returns old 0x00), then reads it back.
        @(negedge clk);
        start_req(1, 1, 2'd1, 8'hC3, 8'h00, 1);
        wait_ack(1, 1, 2'd1, cyc);
        check("write latency B", cyc, 2);
        @(negedge clk);
        start_req(1, 0, 2'd1, 8'h00, 8'hC3, 1);
        wait_ack(1, 0, 2'd1, cyc);

        // Simultaneous after reset: A first, then B; then both again -> A first.
        do_reset();
        order_log.delete();
        start_req(0, 0, 2'd1, 8'h00, 8'hC3, 1);
        start_req(1, 0, 2'd2, 8'h00, 8'h5A, 1);
        wait_ack(0, 0, 2'd1, cyc);
        check("contended A latency", cyc, 2);
        wait_ack(1, 0, 2'd2, cyc);
        @(negedge clk);
        start_req(0, 0, 2'd2, 8'h00, 8'h5A, 1);
        start_req(1, 1, 2'd0, 8'h11, 8'h00, 1);
        wait_ack(0, 0, 2'd2, cyc);
        wait_ack(1, 1, 2'd0, cyc);
        check("contention order len", order_log.size(), 4);
        if (order_log.size() == 4)
            check("contention order", {order_log[0], order_log[1],
                                       order_log[2], order_log[3]}, 4'b0101);

        // Fairness: both reissue right after each ack -> A,B,A,B,A,B.
        @(negedge clk);
        order_log.delete();
        start_req(0, 0, 2'd1, 8'h00, 8'hC3, 1);
        start_req(1, 0, 2'd0, 8'h00, 8'h11, 1);
        for (int i = 0; i < 3; i++) begin
            wait_ack(0, 0, 2'd1, cyc);
            if (i < 2) begin
                @(negedge clk);
                start_req(0, 0, 2'd1, 8'h00, 8'hC3, 1);
            end
            wait_ack(1, 0, 2'd0, cyc);
            if (i < 2) begin
                @(negedge clk);
                start_req(1, 0, 2'd0, 8'h00, 8'h11, 1);
            end
        end
        check("fairness order len", order_log.size(), 6);
        if (order_log.size() == 6)
            check("fairness order", {order_log[0], order_log[1], order_log[2],
                                     order_log[3], order_log[4], order_log[5]},
                  6'b010101);

        // Reset during ACCESS: B's write still commits, no ack.
        @(negedge clk);
        start_req(1, 1, 2'd3, 8'h77, 8'h00, 0);
        @(posedge clk); #1;
        check("busy in ACCESS", busy, 1);
        check("ram_we in ACCESS before clr", ram_we, 1);
        @(negedge clk);
        clr = 1'b1; req_b = 1'b0;
        @(posedge clk); #1;
        check("busy after clr in ACCESS", busy, 0);
        check("ack_b after clr in ACCESS", ack_b, 0);
        check("ram_we after clr", ram_we, 0);
        check("mem[3] committed", mem[3], 8'h77);
        @(negedge clk);
        clr = 1'b0;
        start_req(0, 0, 2'd3, 8'h00, 8'h77, 1);
        wait_ack(0, 0, 2'd3, cyc);

        // Reset during RESP: ack drops and rdata clears.
        @(negedge clk);
        start_req(1, 0, 2'd1, 8'h00, 8'hC3, 1);
        wait_ack(1, 0, 2'd1, cyc);
        clr = 1'b1;
        @(posedge clk); #1;
        check("ack_b after clr in RESP", ack_b, 0);
        check("rdata_b after clr", rdata_b, 0);
        @(negedge clk);
        clr = 1'b0;

        // Isolation: A reads 0x11, B's access must not disturb rdata_a.
        @(negedge clk);
        start_req(0, 0, 2'd0, 8'h00, 8'h11, 1);
        wait_ack(0, 0, 2'd0, cyc);
        @(negedge clk);
        start_req(1, 0, 2'd3, 8'h00, 8'h77, 1);
        wait_ack(1, 0, 2'd3, cyc);
        check("rdata_a isolated", rdata_a, 8'h11);
        check("rdata_b isolation read", rdata_b, 8'h77);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard A drained", exp_a.size(), 0);
        check("scoreboard B drained", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
